// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: fetch-stage widths, FSM state codes and the NOP bubble shared with decode
package cpu_fetch_pkg;
  localparam int FETCH_PC_W = 8;
  localparam int FETCH_INSN_W = 16;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [15:0] NOP_INSN = 16'h0000;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry oldest-first FIFO of {insn, pc} with flush
module fetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int PC_W = FETCH_PC_W,
  parameter int INSN_W = FETCH_INSN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [INSN_W-1:0] push_insn,
  input  logic [PC_W-1:0]   push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        occ,
  output logic [INSN_W-1:0] head_insn,
  output logic [PC_W-1:0]   head_pc
);
  logic [INSN_W+PC_W-1:0] e0, e1;
  logic wr1;
  assign wr1 = occ == 2'd2 || (occ == 2'd1 && !pop);
  assign {head_insn, head_pc} = e0;
  // shift the tail into the head on pop, then write the push into the first free slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      occ <= flush ? 2'd0 : occ + 2'(push) - 2'(pop);
      if (pop) e0 <= e1;
      if (push && !wr1) e0 <= {push_insn, push_pc};
      if (push && wr1) e1 <= {push_insn, push_pc};
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing req/ack word fetches into a 2-deep queue with redirect flush
module if_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int PC_W = FETCH_PC_W,
  parameter int INSN_W = FETCH_INSN_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              insn_valid,
  output logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   insn_pc,
  input  logic              insn_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc
);
  logic [1:0] state, state_n, occ;
  logic [PC_W-1:0] pc, req_addr, head_pc;
  logic [INSN_W-1:0] head_insn;
  logic push, pop, room;
  assign imem_req = state == REQ || state == DRAIN;
  assign imem_addr = req_addr;
  assign insn_valid = occ != 2'd0;
  assign insn = insn_valid ? head_insn : INSN_W'(NOP_INSN);
  assign insn_pc = insn_valid ? head_pc : '0;
  assign pop = insn_valid && insn_ready;
  assign push = state == REQ && imem_ack && !redirect;
  assign room = ({1'b0, occ} + 3'(push) - 3'(pop)) <= 3'd1;
  // a redirect always wins; a stale request in DRAIN is held until its ack retires it
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (!redirect && room) ? REQ : IDLE;
    else if (state == REQ) state_n = imem_ack ? ((push && room) ? REQ : IDLE) : (redirect ? DRAIN : REQ);
    else state_n = imem_ack ? IDLE : DRAIN;
  end
  // pc tracks the next address to fetch; req_addr only moves when a new request launches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_addr <= '0;
    end else begin
      state <= state_n;
      if (redirect) pc <= redirect_pc;
      else if (push) pc <= req_addr + PC_W'(1);
      if (state == IDLE && !redirect && room) req_addr <= pc;
      else if (push && room) req_addr <= req_addr + PC_W'(1);
    end
  end
  fetch_queue #(.PC_W(PC_W), .INSN_W(INSN_W)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_insn(imem_rdata),
    .push_pc(req_addr),
    .pop(pop),
    .flush(redirect),
    .occ(occ),
    .head_insn(head_insn),
    .head_pc(head_pc)
  );
endmodule
